// File: rtl/karatsuba32_seq_ctrl.sv
// Sequential 32x32 -> 64-bit unsigned multiplier controller.
// It feeds the four half-width partial products through one shared external multiplier and accumulates them.
module karatsuba32_seq_ctrl #(
  parameter int N = 32,
  parameter int H = N / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   p,
  output logic [H-1:0]     mul_x,
  output logic [H-1:0]     mul_y,
  input  logic [2*H-1:0]   mul_p,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic [2:0] {
    IDLE,
    LL,
    LH,
    HL,
    HH,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] addend;
  logic [2*N-1:0] mul_p_ext;
  logic           accept;
  logic           handshake;

  assign mul_p_ext = {{(2*N-2*H){1'b0}}, mul_p};
  assign accept    = (state == IDLE) && in_valid;
  assign handshake = (state == DONE) && out_ready;
  assign p         = acc;

  // Outside the multiply states, addend stays zero, so the accumulator holds its value.
  always_comb begin
    state_next = state;
    mul_x      = '0;
    mul_y      = '0;
    addend     = '0;
    in_ready   = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = LL;
      end
      LL: begin
        mul_x      = a_r[H-1:0];
        mul_y      = b_r[H-1:0];
        addend     = mul_p_ext;
        state_next = LH;
      end
      LH: begin
        mul_x      = a_r[H-1:0];
        mul_y      = b_r[N-1:H];
        addend     = mul_p_ext << H;
        state_next = HL;
      end
      HL: begin
        mul_x      = a_r[N-1:H];
        mul_y      = b_r[H-1:0];
        addend     = mul_p_ext << H;
        state_next = HH;
      end
      HH: begin
        mul_x      = a_r[N-1:H];
        mul_y      = b_r[N-1:H];
        addend     = mul_p_ext << N;
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      state     <= state_next;
      out_valid <= (state_next == DONE);
      if (accept) begin
        a_r <= a;
        b_r <= b;
        acc <= '0;
      end else begin
        acc <= acc + addend;
      end
      if (handshake) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_karatsuba32_seq_ctrl.sv
// Testbench for karatsuba32_seq_ctrl, using an exact shared multiplier.
// It checks directed and random operand pairs against a plain 64-bit product reference.
module tb_karatsuba32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] p;
  logic [15:0] mul_x;
  logic [15:0] mul_y;
  logic [31:0] mul_p;
  logic        busy;
  logic [15:0] op_count;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          cyc    = 0;
  logic [15:0] model_count = '0;
  logic [63:0] last_p;

  karatsuba32_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_p     (mul_p),
    .busy      (busy),
    .op_count  (op_count)
  );

  // The shared multiplier is modelled as exact.
  assign mul_p = 32'(mul_x) * 32'(mul_y);

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from IDLE through its result handshake.
  // While the result is stalled, the task drives nxt_a/nxt_b with in_valid asserted.
  // If hold_next is set, in_valid stays high past the handshake.
  task automatic applyStimulus(input logic [31:0] op_a, input logic [31:0] op_b, input int stall,
                               input logic [31:0] nxt_a, input logic [31:0] nxt_b, input bit hold_next);
    logic [63:0] exp_p;
    logic [15:0] xs [4];
    logic [15:0] ys [4];
    exp_p = {32'd0, op_a} * {32'd0, op_b};
    xs = '{op_a[15:0], op_a[15:0], op_a[31:16], op_a[31:16]};
    ys = '{op_b[15:0], op_b[31:16], op_b[15:0], op_b[31:16]};
    checkOutput("in_ready_idle", in_ready, 1);
    checkOutput("busy_idle", busy, 0);
    checkOutput("mul_x_idle", mul_x, 0);
    in_valid  = 1'b1;
    a         = op_a;
    b         = op_b;
    out_ready = 1'b0;
    tick();
    in_valid = 1'($urandom);
    a        = $urandom;
    b        = $urandom;
    for (int c = 0; c < 4; c++) begin
      checkOutput("mul_x_seq", mul_x, xs[c]);
      checkOutput("mul_y_seq", mul_y, ys[c]);
      checkOutput("out_valid_low", out_valid, 0);
      checkOutput("in_ready_busy", in_ready, 0);
      tick();
    end
    checkOutput("out_valid_done", out_valid, 1);
    checkOutput("product", p, exp_p);
    checkOutput("mul_x_done", mul_x, 0);
    checkOutput("mul_y_done", mul_y, 0);
    last_p = p;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      a        = nxt_a;
      b        = nxt_b;
      tick();
      checkOutput("stall_out_valid", out_valid, 1);
      checkOutput("stall_p_stable", p, exp_p);
      checkOutput("stall_in_ready", in_ready, 0);
      checkOutput("stall_op_count", op_count, model_count);
    end
    in_valid  = hold_next;
    a         = nxt_a;
    b         = nxt_b;
    out_ready = 1'b1;
    tick();
    out_ready   = 1'b0;
    model_count = model_count + 16'd1;
    checkOutput("op_count_after", op_count, model_count);
    checkOutput("out_valid_after", out_valid, 0);
    checkOutput("in_ready_after", in_ready, 1);
  endtask

  initial begin
    int rises[$];
    logic [31:0] ra;
    logic [31:0] rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_p", p, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_op_count", op_count, 0);
    rst = 1'b0;
    tick();

    // Abort an operation while it is in LH; its result must never appear.
    in_valid = 1'b1;
    a        = $urandom;
    b        = $urandom;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_p", p, 0);
    checkOutput("abort_mul_x", mul_x, 0);
    checkOutput("abort_mul_y", mul_y, 0);
    checkOutput("abort_busy", busy, 0);
    #1 rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("abort_no_valid", out_valid, 0);
      checkOutput("abort_op_count", op_count, 0);
      tick();
    end
    applyStimulus(32'd7, 32'd9, 0, 32'd0, 32'd0, 1'b0);
    checkOutput("seven_times_nine", last_p, 64'd63);

    applyStimulus(32'h0001_0002, 32'h0003_0004, 0, 32'd0, 32'd0, 1'b0);
    checkOutput("basic_product", last_p, 64'h0000_0003_000A_0008);
    checkOutput("basic_op_count", op_count, 16'd2);

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd0, 32'd0, 1'b0);
    checkOutput("max_product", last_p, 64'hFFFF_FFFE_0000_0001);

    applyStimulus(32'hAAAA_5555, 32'h1234_8765, 0, 32'd0, 32'd0, 1'b0);

    // Backpressure: keep offering new operands while the result is held; after release they are accepted.
    ra = $urandom;
    rb = $urandom;
    applyStimulus(32'hDEAD_BEEF, 32'h0BAD_F00D, 5, ra, rb, 1'b1);
    applyStimulus(ra, rb, 0, 32'd0, 32'd0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus($urandom, $urandom, int'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
    end

    // Back-to-back throughput with out_ready held high.
    in_valid  = 1'b1;
    a         = 32'hFFFF_FFFF;
    b         = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && rises.size() < 3; i++) begin
      tick();
      if (out_valid) begin
        checkOutput("b2b_product", p, 64'hFFFF_FFFE_0000_0001);
        rises.push_back(cyc);
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checkOutput("b2b_result_count", rises.size(), 3);
    if (rises.size() == 3) begin
      checkOutput("b2b_interval_1", rises[1] - rises[0], 6);
      checkOutput("b2b_interval_2", rises[2] - rises[1], 6);
      model_count = model_count + 16'd3;
    end
    checkOutput("b2b_op_count", op_count, model_count);
    checkOutput("b2b_idle", in_ready, 1);

    // Asynchronous reset while a result is waiting in DONE.
    in_valid = 1'b1;
    a        = $urandom;
    b        = $urandom;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    checkOutput("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("done_rst_out_valid", out_valid, 0);
    checkOutput("done_rst_p", p, 0);
    checkOutput("done_rst_in_ready", in_ready, 1);
    checkOutput("done_rst_op_count", op_count, 0);
    #1 rst = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("post_rst_busy", busy, 0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
